// File: rtl/math_cabs_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : math_cabs_seq_if
//  Brief    : Sample-in / magnitude-out valid-ready bundle for math_cabs_seq.
//  Revision : 1.0
// ============================================================================
interface math_cabs_seq_if #(
   parameter int DIN_WIDTH  = 12,
   parameter int DOUT_WIDTH = 13,
   parameter int CHAN_WIDTH = 3
);
   logic                         s_valid;
   logic                         s_ready;
   logic [CHAN_WIDTH-1:0]        s_chan;
   logic                         mode;
   logic signed [DIN_WIDTH-1:0]  dina;
   logic signed [DIN_WIDTH-1:0]  dinb;
   logic                         m_valid;
   logic                         m_ready;
   logic [CHAN_WIDTH-1:0]        m_chan;
   logic [DOUT_WIDTH-1:0]        dout;

   modport master (
      output s_valid, s_chan, mode, dina, dinb, m_ready,
      input  s_ready, m_valid, m_chan, dout
   );

   modport slave (
      input  s_valid, s_chan, mode, dina, dinb, m_ready,
      output s_ready, m_valid, m_chan, dout
   );
endinterface
`default_nettype wire

// File: rtl/math_cabs_seq.sv
`default_nettype none
// ============================================================================
//  Module   : math_cabs_seq
//  Brief    : Sequential |a + jb|: exact bit-serial isqrt or alpha-max-beta-min.
//  Revision : 1.0
// ============================================================================
module math_cabs_seq #(
   parameter int DIN_WIDTH  = 12,
   parameter int DOUT_WIDTH = 13,
   parameter int CHAN_WIDTH = 3
) (
   input  logic           clk,
   input  logic           rst,
   math_cabs_seq_if.slave bus
);
   localparam int c_SQ_W  = 2 * DIN_WIDTH;
   localparam int c_REM_W = DIN_WIDTH + 4;
   localparam int c_CNT_W = $clog2(DIN_WIDTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SQUARE = 2'd1,
      ST_ROOT   = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   state_t                 r_state;
   state_t                 w_state_next;
   logic                   r_s_ready;
   logic                   r_m_valid;
   logic [CHAN_WIDTH-1:0]  r_chan;
   logic [CHAN_WIDTH-1:0]  r_m_chan;
   logic                   r_mode;
   logic [DIN_WIDTH:0]     r_a;
   logic [DIN_WIDTH:0]     r_b;
   logic [c_SQ_W-1:0]      r_sq;
   logic [c_REM_W-1:0]     r_rem;
   logic [DIN_WIDTH-1:0]   r_root;
   logic [c_CNT_W-1:0]     r_iter;
   logic [DOUT_WIDTH-1:0]  r_dout;

   logic                   w_accept;
   logic                   w_out_xfer;
   logic                   w_last_iter;
   logic [DIN_WIDTH:0]     w_dina_ext;
   logic [DIN_WIDTH:0]     w_dinb_ext;
   logic [DIN_WIDTH:0]     w_abs_a;
   logic [DIN_WIDTH:0]     w_abs_b;
   logic [c_SQ_W-1:0]      w_a_wide;
   logic [c_SQ_W-1:0]      w_b_wide;
   logic [c_SQ_W-1:0]      w_sum_sq;
   logic [DIN_WIDTH:0]     w_max;
   logic [DIN_WIDTH:0]     w_min;
   logic [DIN_WIDTH+2:0]   w_min3;
   logic [DIN_WIDTH+2:0]   w_approx;
   logic [1:0]             w_pair;
   logic [c_REM_W-1:0]     w_rem_shift;
   logic [c_REM_W-1:0]     w_sub_term;
   logic [c_REM_W-1:0]     w_add_term;
   logic [c_REM_W-1:0]     w_rem_next;
   logic [DIN_WIDTH-1:0]   w_root_next;

   assign w_accept    = r_s_ready & bus.s_valid;
   assign w_out_xfer  = r_m_valid & bus.m_ready;
   assign w_last_iter = (r_iter == c_CNT_W'(DIN_WIDTH - 1));

   // One extra bit so that the most negative input has a representable magnitude
   assign w_dina_ext = {bus.dina[DIN_WIDTH-1], bus.dina};
   assign w_dinb_ext = {bus.dinb[DIN_WIDTH-1], bus.dinb};
   assign w_abs_a    = w_dina_ext[DIN_WIDTH] ? -w_dina_ext : w_dina_ext;
   assign w_abs_b    = w_dinb_ext[DIN_WIDTH] ? -w_dinb_ext : w_dinb_ext;

   assign w_a_wide = c_SQ_W'(r_a);
   assign w_b_wide = c_SQ_W'(r_b);
   assign w_sum_sq = w_a_wide * w_a_wide + w_b_wide * w_b_wide;

   assign w_max    = (r_a >= r_b) ? r_a : r_b;
   assign w_min    = (r_a >= r_b) ? r_b : r_a;
   assign w_min3   = {2'b00, w_min} + {1'b0, w_min, 1'b0};
   assign w_approx = {2'b00, w_max} + (w_min3 >> 3);

   // Non-restoring step: remainder sign picks add/subtract, no correction pass needed
   assign w_pair      = r_sq[c_SQ_W-1 -: 2];
   assign w_rem_shift = (r_rem << 2) | c_REM_W'(w_pair);
   assign w_sub_term  = c_REM_W'({r_root, 2'b01});
   assign w_add_term  = c_REM_W'({r_root, 2'b11});
   assign w_rem_next  = r_rem[c_REM_W-1] ? (w_rem_shift + w_add_term)
                                          : (w_rem_shift - w_sub_term);
   assign w_root_next = {r_root[DIN_WIDTH-2:0], ~w_rem_next[c_REM_W-1]};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:   if (w_accept)    w_state_next = ST_SQUARE;
         ST_SQUARE: w_state_next = r_mode ? ST_DONE : ST_ROOT;
         ST_ROOT:   if (w_last_iter) w_state_next = ST_DONE;
         ST_DONE:   if (w_out_xfer)  w_state_next = ST_IDLE;
         default:   w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s_ready <= 1'b0;
         r_m_valid <= 1'b0;
         r_m_chan  <= '0;
         r_dout    <= '0;
         r_chan    <= '0;
         r_mode    <= 1'b0;
         r_a       <= '0;
         r_b       <= '0;
         r_sq      <= '0;
         r_rem     <= '0;
         r_root    <= '0;
         r_iter    <= '0;
      end else begin
         // Registered from the next state keeps s_ready free of input paths
         r_s_ready <= (w_state_next == ST_IDLE);
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_a    <= w_abs_a;
                  r_b    <= w_abs_b;
                  r_chan <= bus.s_chan;
                  r_mode <= bus.mode;
               end
            end
            ST_SQUARE: begin
               if (r_mode) begin
                  r_dout    <= DOUT_WIDTH'(w_approx);
                  r_m_chan  <= r_chan;
                  r_m_valid <= 1'b1;
               end else begin
                  r_sq   <= w_sum_sq;
                  r_rem  <= '0;
                  r_root <= '0;
                  r_iter <= '0;
               end
            end
            ST_ROOT: begin
               r_sq   <= r_sq << 2;
               r_rem  <= w_rem_next;
               r_root <= w_root_next;
               r_iter <= r_iter + 1'b1;
               if (w_last_iter) begin
                  r_dout    <= DOUT_WIDTH'(w_root_next);
                  r_m_chan  <= r_chan;
                  r_m_valid <= 1'b1;
               end
            end
            ST_DONE: begin
               if (w_out_xfer) begin
                  r_m_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.s_ready = r_s_ready;
   assign bus.m_valid = r_m_valid;
   assign bus.m_chan  = r_m_chan;
   assign bus.dout    = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_math_cabs_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_math_cabs_seq
//  Brief    : Directed checks of math_cabs_seq latency, values and handshake.
//  Revision : 1.0
// ============================================================================
module tb_math_cabs_seq;
   localparam int DW = 12;
   localparam int OW = 13;
   localparam int CW = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   exp_d_q[$];
   int   exp_c_q[$];

   math_cabs_seq_if #(.DIN_WIDTH(DW), .DOUT_WIDTH(OW), .CHAN_WIDTH(CW)) bus ();

   math_cabs_seq #(.DIN_WIDTH(DW), .DOUT_WIDTH(OW), .CHAN_WIDTH(CW)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int ref_mag(input int a, input int b, input bit md);
      longint aa, bb, s, r, mx, mn;
      aa = (a < 0) ? -a : a;
      bb = (b < 0) ? -b : b;
      if (md) begin
         mx = (aa > bb) ? aa : bb;
         mn = (aa > bb) ? bb : aa;
         return int'(mx + (3 * mn) / 8);
      end
      s = aa * aa + bb * bb;
      r = 0;
      for (int bit_i = DW; bit_i >= 0; bit_i--) begin
         if ((r + (64'd1 << bit_i)) * (r + (64'd1 << bit_i)) <= s) r = r + (64'd1 << bit_i);
      end
      return int'(r);
   endfunction

   // Called at a falling edge; returns at the falling edge just after the accept edge
   task automatic send_in(input int a, input int b, input bit md, input int ch, output int t_acc);
      int k;
      k = 0;
      while (bus.s_ready !== 1'b1 && k < 64) begin
         @(negedge clk);
         k++;
      end
      check_val("s_ready before send", bus.s_ready, 1);
      bus.dina    = DW'(a);
      bus.dinb    = DW'(b);
      bus.mode    = md;
      bus.s_chan  = CW'(ch);
      bus.s_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      t_acc       = cyc;
      bus.s_valid = 1'b0;
   endtask

   task automatic wait_valid(output int k);
      k = 1;
      while (bus.m_valid !== 1'b1 && k < 100) begin
         @(negedge clk);
         k++;
      end
   endtask

   task automatic xfer(input int a, input int b, input bit md, input int ch,
                       input int exp_d, input int exp_lat, input string tag);
      int k, t;
      send_in(a, b, md, ch, t);
      wait_valid(k);
      check_val({tag, " latency"}, k, exp_lat);
      check_val({tag, " dout"}, bus.dout, exp_d);
      check_val({tag, " m_chan"}, bus.m_chan, ch);
      @(negedge clk);
      check_val({tag, " m_valid drop"}, bus.m_valid, 0);
      check_val({tag, " s_ready back"}, bus.s_ready, 1);
   endtask

   initial begin
      int k, t, highs;
      int va[8] = '{100, -512, 1, -2048, 1500, -7, 2047, 0};
      int vb[8] = '{-37, 300, 1, 2047, 1500, -24, 2047, -2048};

      bus.s_valid = 1'b0;
      bus.m_ready = 1'b1;
      bus.mode    = 1'b0;
      bus.s_chan  = '0;
      bus.dina    = '0;
      bus.dinb    = '0;

      // Reset held for two edges
      @(negedge clk);
      @(negedge clk);
      check_val("rst s_ready", bus.s_ready, 0);
      check_val("rst m_valid", bus.m_valid, 0);
      check_val("rst dout", bus.dout, 0);
      check_val("rst m_chan", bus.m_chan, 0);
      rst = 1'b0;
      @(negedge clk);
      check_val("post-rst s_ready", bus.s_ready, 1);
      check_val("post-rst m_valid", bus.m_valid, 0);

      xfer(3, 4, 1'b0, 5, 5, 14, "3,4 exact");
      xfer(-2048, -2048, 1'b0, 1, 2896, 14, "min,min exact");
      xfer(-2048, -2048, 1'b1, 2, 2816, 2, "min,min approx");
      xfer(-3, 0, 1'b0, 3, 3, 14, "-3,0 exact");
      xfer(0, 0, 1'b0, 4, 0, 14, "0,0 exact");
      xfer(2047, -1, 1'b0, 7, 2047, 14, "2047,-1 exact");
      xfer(3, 4, 1'b1, 0, 5, 2, "3,4 approx");
      xfer(2047, -1, 1'b1, 6, 2047, 2, "2047,-1 approx");

      // Downstream stalls: result and tag must hold
      bus.m_ready = 1'b0;
      send_in(5, 12, 1'b0, 6, t);
      wait_valid(k);
      check_val("stall latency", k, 14);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_val("stall dout", bus.dout, 13);
         check_val("stall m_chan", bus.m_chan, 6);
         check_val("stall m_valid", bus.m_valid, 1);
         check_val("stall s_ready", bus.s_ready, 0);
      end
      bus.m_ready = 1'b1;
      @(negedge clk);
      check_val("release m_valid", bus.m_valid, 0);
      check_val("release s_ready", bus.s_ready, 1);

      // Reset lands on the sixth root iteration
      send_in(7, 7, 1'b0, 2, t);
      repeat (6) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_val("abort s_ready", bus.s_ready, 0);
      highs = 0;
      for (int i = 0; i < 30; i++) begin
         if (bus.m_valid === 1'b1) highs++;
         @(negedge clk);
      end
      check_val("abort no result", highs, 0);
      xfer(6, 8, 1'b0, 3, 10, 14, "6,8 after abort");

      // Back-to-back mixed stream against the reference model
      fork
         begin
            int t_prev;
            bit m_prev;
            t_prev = 0;
            m_prev = 1'b0;
            for (int i = 0; i < 8; i++) begin
               exp_d_q.push_back(ref_mag(va[i], vb[i], i[0]));
               exp_c_q.push_back(i);
               send_in(va[i], vb[i], i[0], i, t);
               if (i > 0) check_val("stream spacing", t - t_prev, m_prev ? 3 : DW + 3);
               t_prev = t;
               m_prev = i[0];
            end
         end
         begin
            int got, waited;
            got    = 0;
            waited = 0;
            while (got < 8 && waited < 600) begin
               @(negedge clk);
               waited++;
               if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
                  if (exp_d_q.size() == 0) begin
                     check_val("stream extra result", 1, 0);
                  end else begin
                     check_val("stream dout", bus.dout, exp_d_q.pop_front());
                     check_val("stream m_chan", bus.m_chan, exp_c_q.pop_front());
                  end
                  got++;
               end
            end
            check_val("stream count", got, 8);
         end
      join

      highs = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.m_valid === 1'b1) highs++;
      end
      check_val("stream no duplicates", highs, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
